// File: rtl/led_anim_gen.sv
// ---------------------------------------------------------------------------
// led_anim_gen
//   Parametrised LED animation engine. A runtime-programmable prescaler
//   produces one animation step every `period` clocks (0 acts as 1). Each
//   step either loads a new pattern or advances the current one:
//     WALK   : single lit LED rotating upward
//     BOUNCE : single lit LED sweeping up then back down
//     FILL   : bar graph filling from bit0, then clearing
//     BLINK  : all LEDs toggling together
//   Mode requests are sampled only on a step, so the animation never glitches
//   mid-interval.
//
// Ports
//   clk      : system clock
//   rst      : asynchronous active-low reset
//   en       : 1 = run, 0 = freeze prescaler and pattern
//   mode     : requested animation (0 WALK, 1 BOUNCE, 2 FILL, 3 BLINK)
//   period   : clocks per animation step, 0 treated as 1
//   led_out  : registered LED drive
//   tick     : 1-cycle pulse in the cycle led_out shows a new step
//   wrap     : 1-cycle pulse when an advance returns to the initial pattern
//   cur_mode : mode currently animating
// ---------------------------------------------------------------------------
module led_anim_gen #(
  parameter int N_LED = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] period,
  output logic [N_LED-1:0] led_out,
  output logic             tick,
  output logic             wrap,
  output logic [1:0]       cur_mode
);

  typedef enum logic [1:0] {
    WALK   = 2'd0,
    BOUNCE = 2'd1,
    FILL   = 2'd2,
    BLINK  = 2'd3
  } mode_e;

  localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
  localparam logic [N_LED-1:0] BIT0     = N_LED'(1);

  mode_e            cur_state;
  mode_e            req_mode;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] p_eff;
  logic [DIV_W-1:0] last_cnt;
  logic             step_due;
  logic             load_pending;
  logic             dir_up;

  logic [N_LED-1:0] next_led;
  logic             next_dir_up;
  logic             next_wrap;

  // Starting pattern of each animation.
  function automatic logic [N_LED-1:0] init_pattern(input mode_e m);
    case (m)
      WALK, BOUNCE: init_pattern = BIT0;
      FILL:         init_pattern = '0;
      default:      init_pattern = '1;
    endcase
  endfunction

  assign req_mode = mode_e'(mode);
  assign cur_mode = cur_state;

  // Zero period behaves as one. The >= compare lets a period that shrinks
  // below the running count fire on the very next edge instead of waiting
  // for the counter to wrap around.
  assign p_eff    = (period == '0) ? ONE : period;
  assign last_cnt = p_eff - ONE;
  assign step_due = (cnt >= last_cnt);

  // Next pattern for an advance step of the mode already animating.
  always_comb begin
    next_led    = led_out;
    next_dir_up = dir_up;
    next_wrap   = 1'b0;
    case (cur_state)
      WALK: begin
        next_led  = {led_out[N_LED-2:0], led_out[N_LED-1]};
        next_wrap = (next_led == BIT0);
      end
      BOUNCE: begin
        // Direction flips upon arriving at an end bit so each end is lit
        // exactly once per pass; only the return to bit0 counts as a wrap.
        if (dir_up) begin
          next_led = led_out << 1;
          if (next_led[N_LED-1]) begin
            next_dir_up = 1'b0;
          end
        end else begin
          next_led = led_out >> 1;
          if (next_led[0]) begin
            next_dir_up = 1'b1;
            next_wrap   = 1'b1;
          end
        end
      end
      FILL: begin
        if (&led_out) begin
          next_led  = '0;
          next_wrap = 1'b1;
        end else begin
          next_led = {led_out[N_LED-2:0], 1'b1};
        end
      end
      default: begin
        next_led  = ~led_out;
        next_wrap = &next_led;
      end
    endcase
  end

  // Prescaler plus animation state. A load (after reset or on a mode change)
  // takes priority over an advance and never reports a wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= '0;
      led_out      <= '0;
      tick         <= 1'b0;
      wrap         <= 1'b0;
      cur_state    <= WALK;
      load_pending <= 1'b1;
      dir_up       <= 1'b1;
    end else if (!en) begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end else if (step_due) begin
      cnt  <= '0;
      tick <= 1'b1;
      if (load_pending || (req_mode != cur_state)) begin
        cur_state    <= req_mode;
        led_out      <= init_pattern(req_mode);
        load_pending <= 1'b0;
        dir_up       <= 1'b1;
        wrap         <= 1'b0;
      end else begin
        led_out <= next_led;
        dir_up  <= next_dir_up;
        wrap    <= next_wrap;
      end
    end else begin
      cnt  <= cnt + ONE;
      tick <= 1'b0;
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_led_anim_gen.sv
// ---------------------------------------------------------------------------
// tb_led_anim_gen
//   Drives led_anim_gen (N_LED=8) with directed sequences followed by
//   randomized traffic. The reference model describes each animation as a
//   phase index into its repeating sequence, the LED value being a pure
//   function of (mode, phase). Expected outputs are queued per clock and a
//   separate monitor pops and compares them after every rising edge.
// ---------------------------------------------------------------------------
module tb_led_anim_gen;

  localparam int N = 8;
  localparam int W = 16;

  typedef struct packed {
    logic [N-1:0] led;
    logic         tick;
    logic         wrap;
    logic [1:0]   cm;
  } obs_t;

  logic         clk;
  logic         rst;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] period;
  logic [N-1:0] led_out;
  logic         tick;
  logic         wrap;
  logic [1:0]   cur_mode;

  obs_t exp_q[$];
  int   compared;
  int   mismatched;
  int   cycle_no;

  // Reference model state
  int   m_cnt;
  int   m_phase;
  int   m_cur;
  bit   m_pending;
  obs_t m_out;

  led_anim_gen #(.N_LED(N), .DIV_W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .period   (period),
    .led_out  (led_out),
    .tick     (tick),
    .wrap     (wrap),
    .cur_mode (cur_mode)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Length of each animation's repeating sequence.
  function automatic int seq_len(input int m);
    case (m)
      0:       return N;
      1:       return 2 * N - 2;
      2:       return N + 1;
      default: return 2;
    endcase
  endfunction

  // LED value at a given phase of an animation.
  function automatic logic [N-1:0] pattern(input int m, input int k);
    int v;
    case (m)
      0:       v = 1 << k;
      1:       v = (k < N) ? (1 << k) : (1 << (2 * N - 2 - k));
      2:       v = (1 << k) - 1;
      default: v = (k % 2 == 0) ? 255 : 0;
    endcase
    return N'(v);
  endfunction

  task automatic modelReset();
    m_cnt     = 0;
    m_phase   = 0;
    m_cur     = 0;
    m_pending = 1'b1;
    m_out     = '0;
  endtask

  // Advance the model by one rising edge using the currently driven inputs.
  task automatic modelStep();
    int p;
    if (!rst) begin
      modelReset();
    end else if (!en) begin
      m_out.tick = 1'b0;
      m_out.wrap = 1'b0;
    end else begin
      p = (period == 0) ? 1 : int'(period);
      if (m_cnt >= p - 1) begin
        m_cnt      = 0;
        m_out.tick = 1'b1;
        if (m_pending || int'(mode) != m_cur) begin
          m_cur      = int'(mode);
          m_phase    = 0;
          m_pending  = 1'b0;
          m_out.wrap = 1'b0;
        end else begin
          m_phase    = (m_phase + 1) % seq_len(m_cur);
          m_out.wrap = (m_phase == 0);
        end
        m_out.led = pattern(m_cur, m_phase);
        m_out.cm  = 2'(m_cur);
      end else begin
        m_cnt      = m_cnt + 1;
        m_out.tick = 1'b0;
        m_out.wrap = 1'b0;
      end
    end
  endtask

  task automatic checkOutput(input string name, input obs_t want, input obs_t got);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s @cycle %0d: got led=%h tick=%b wrap=%b cur_mode=%0d, want led=%h tick=%b wrap=%b cur_mode=%0d",
               name, cycle_no, got.led, got.tick, got.wrap, got.cm,
               want.led, want.tick, want.wrap, want.cm);
    end
  endtask

  // Drive inputs between rising edges and queue the response expected
  // after the following rising edge.
  task automatic applyStimulus(input logic r, input logic e, input logic [1:0] m,
                               input logic [W-1:0] p, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rst    = r;
      en     = e;
      mode   = m;
      period = p;
      modelStep();
      exp_q.push_back(m_out);
    end
  endtask

  // Assert reset away from any clock edge and require the outputs to clear
  // immediately, before the next rising edge arrives.
  task automatic asyncResetCheck();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_reset", obs_t'(0), {led_out, tick, wrap, cur_mode});
    modelReset();
    exp_q.push_back(m_out);
  endtask

  // Monitor: compare DUT outputs with the queued expectation each cycle.
  initial begin : monitor
    obs_t want;
    forever begin
      @(posedge clk);
      #1;
      cycle_no++;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        checkOutput("step", want, {led_out, tick, wrap, cur_mode});
      end
    end
  end

  initial begin : stimulus
    logic         r_en;
    logic [1:0]   r_mode;
    logic [W-1:0] r_period;
    compared   = 0;
    mismatched = 0;
    cycle_no   = 0;
    rst        = 1'b1;
    en         = 1'b0;
    mode       = 2'd0;
    period     = W'(4);
    modelReset();
    #7 rst = 1'b0;

    // WALK at period 4, through a full rotation and wrap
    applyStimulus(1'b1, 1'b1, 2'd0, W'(4), 40);
    // BOUNCE at period 1, more than a full pass
    applyStimulus(1'b1, 1'b1, 2'd1, W'(1), 30);
    // FILL at period 2, more than a full 9-step cycle
    applyStimulus(1'b1, 1'b1, 2'd2, W'(2), 25);
    // WALK then a mid-interval switch to BLINK
    applyStimulus(1'b1, 1'b1, 2'd0, W'(4), 14);
    applyStimulus(1'b1, 1'b1, 2'd3, W'(4), 16);
    // Freeze while the mode input wanders; it must be ignored
    applyStimulus(1'b1, 1'b0, 2'd2, W'(4), 10);
    applyStimulus(1'b1, 1'b1, 2'd3, W'(4), 6);
    // Zero period acts as one
    applyStimulus(1'b1, 1'b1, 2'd0, W'(0), 8);
    // Long period cut short while the counter is far beyond the new limit
    applyStimulus(1'b1, 1'b1, 2'd0, W'(100), 50);
    applyStimulus(1'b1, 1'b1, 2'd0, W'(3), 12);
    // Reset mid-BOUNCE while sweeping down at 0x20, then restart
    asyncResetCheck();
    applyStimulus(1'b1, 1'b1, 2'd1, W'(1), 10);
    asyncResetCheck();
    applyStimulus(1'b1, 1'b1, 2'd1, W'(1), 6);

    // Randomized traffic
    r_mode   = 2'd0;
    r_period = W'(2);
    for (int i = 0; i < 600; i++) begin
      r_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 29) == 0) r_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) r_period = W'($urandom_range(0, 6));
      if ($urandom_range(0, 199) == 0) begin
        asyncResetCheck();
      end else begin
        applyStimulus(1'b1, r_en, r_mode, r_period, 1);
      end
    end

    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
